id_exe_stage_reg: RTL and testbench
===================================

Name: id_exe_stage_reg

Overview:
- Pipeline register between the ID stage (control unit plus condition check) and the EXE stage of the ARM core.
- Latches decoded control and datapath fields each cycle.
- Converts an instruction whose condition fails (cond_state=0) into a bubble by zeroing its side-effect enables.
- Honours branch flush, hazard bubble insertion and memory-stall hold.

Parameters:
- DATA_W, 32, width of PC and operand values
- EXE_CMD_W, 4, ALU command width (`EXE_CMD_LEN)
- REG_ADDR_W, 4, register-file index width

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- mem_stall  in  1  hold every register (downstream memory busy)
- flush  in  1  branch taken in EXE; kill the ID instruction
- hazard  in  1  data hazard; insert a bubble
- valid_in  in  1  ID holds a real instruction
- cond_state  in  1  result of the ID condition check
- wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in  in  1 each  control enables from the control unit
- exe_cmd_in  in  EXE_CMD_W  ALU command
- imm_in  in  1  immediate-operand select
- pc_in, val_rn_in, val_rm_in  in  DATA_W each  PC+4 and register values
- shift_operand_in  in  12  shifter operand
- signed_imm_24_in  in  24  branch offset
- dest_in  in  REG_ADDR_W  destination register
- stat_reg_in  in  `STATUS_REG_LEN  current flags {z,c,n,v}; carry is consumed by the ALU
- valid_out, wb_en, mem_r_en, mem_w_en, b, s, exe_cmd, imm, pc, val_rn, val_rm, shift_operand, signed_imm_24, dest, stat_reg  out  widths as the matching inputs  registered copies

Behaviour:
- One-cycle latency. All outputs are registered, with no combinational input-to-output path.
- Priority each edge: rst > mem_stall > flush > hazard > load.
- rst: every output register is cleared to 0. Bubble state is valid_out=0 with all enables 0. Clears mid-stall as well.
- mem_stall=1: every register holds its value. This holds even when flush or hazard is also asserted; EXE re-asserts flush on the next cycle.
- flush=1 (no stall):
  - valid_out, wb_en, mem_r_en, mem_w_en, b and s are cleared to 0.
  - The datapath fields still load from the inputs; their values are don't-care.
- hazard=1 (no stall, no flush): same bubble as flush.
- load (none of the above):
  - Control signal commit condition: commit = valid_in & cond_state.
  - valid_out <= commit.
  - Each enable <= enable_in & commit.
  - exe_cmd, imm and all datapath fields load unconditionally.
- Squashed instruction (cond_state=0):
  - Never writes back, never accesses memory, never branches, never updates flags.
  - dest is still loaded but is ignored because wb_en=0.
- AL condition gives cond_state=1, so the instruction always commits.
- No state machine beyond the register; the two-state valid bit is the only "state".

Optional Feature:
- Macro: COND_STATS_EN.
- Enabled:
  - Adds outputs exec_count and squash_count, 32 bits each.
  - On a load cycle with valid_in=1, exec_count increments if cond_state=1, otherwise squash_count increments.
  - No increment on stall, flush or hazard cycles.
  - Both counters wrap from 0xFFFFFFFF to 0 and clear on rst.
- Disabled: neither the ports nor the counter logic exist; all other behaviour is identical.

Decomposition:
- Widths go into the shared defines.v: `EXE_CMD_LEN, `REG_FILE_ADDR_LEN, `SHIFT_OPERAND_LEN=12, `SIGNED_IMM_LEN=24, `STATUS_REG_LEN=4.
- One natural sub-module, pipe_reg:
  - Parameterised WIDTH.
  - Inputs: clk, rst, hold, clear, d.
  - Output: q.
  - Clear value 0.
- The enable group instantiates pipe_reg with clear = flush|hazard|~commit; the datapath group instantiates it with clear=0.

Test Plan:
- rst=1 for 2 cycles with all inputs driven to 1 -> every output 0, valid_out=0.
- valid_in=1, cond_state=1, wb_en_in=1, exe_cmd_in=4'b0010, val_rn_in=0x00000005, dest_in=3 -> next cycle wb_en=1, exe_cmd=4'b0010, val_rn=5, dest=3, valid_out=1.
- Same stimulus with cond_state=0 and mem_w_en_in=1 -> next cycle valid_out=0, wb_en=0, mem_w_en=0; dest=3 loaded (COND_STATS_EN: squash_count=1).
- Load pc_in=0x10, then 3 cycles of mem_stall=1 with pc_in=0x20 and flush=1 -> pc stays 0x10 and enables unchanged; after stall drops with flush=1 -> enables 0, valid_out=0.
- hazard=1 with a valid AL instruction carrying b_in=1 -> b=0, valid_out=0; hazard drops -> b=1 on the next edge.
- COND_STATS_EN: preload exec_count near wrap via 2^32-1 committed loads (or force), then one more commit -> exec_count=0; rst mid-run -> both counters 0.

Source files
------------

// File: rtl/id_exe_stage_reg_pkg.sv
// id_exe_stage_reg_pkg: shared widths, control bundle and commit helper for the ID/EXE register
package id_exe_stage_reg_pkg;
  localparam int EXE_CMD_LEN       = 4;
  localparam int REG_FILE_ADDR_LEN = 4;
  localparam int SHIFT_OPERAND_LEN = 12;
  localparam int SIGNED_IMM_LEN    = 24;
  localparam int STATUS_REG_LEN    = 4;
  typedef struct packed {
    logic valid;
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
    logic b;
    logic s;
  } ctrl_t;
  function automatic logic commit_of(input logic valid, input logic cond);
    return valid & cond;
  endfunction
endpackage

// File: rtl/id_exe_stage_reg_pipe_reg.sv
// id_exe_stage_reg_pipe_reg: generic register with sync reset, hold and clear-to-zero (rst > hold > clear)
module id_exe_stage_reg_pipe_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_d, q_q;
  always_comb q_d = rst ? '0 : hold ? q_q : clear ? '0 : d;
  always_ff @(posedge clk) q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/id_exe_stage_reg.sv
// id_exe_stage_reg: ID/EXE pipeline register with flush, hazard bubble, stall hold and condition squash.
// Optional COND_STATS_EN adds exec_count/squash_count outputs.
module id_exe_stage_reg
  import id_exe_stage_reg_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int EXE_CMD_W  = EXE_CMD_LEN,
  parameter int REG_ADDR_W = REG_FILE_ADDR_LEN
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_stall,
  input  logic                         flush,
  input  logic                         hazard,
  input  logic                         valid_in,
  input  logic                         cond_state,
  input  logic                         wb_en_in,
  input  logic                         mem_r_en_in,
  input  logic                         mem_w_en_in,
  input  logic                         b_in,
  input  logic                         s_in,
  input  logic [EXE_CMD_W-1:0]         exe_cmd_in,
  input  logic                         imm_in,
  input  logic [DATA_W-1:0]            pc_in,
  input  logic [DATA_W-1:0]            val_rn_in,
  input  logic [DATA_W-1:0]            val_rm_in,
  input  logic [SHIFT_OPERAND_LEN-1:0] shift_operand_in,
  input  logic [SIGNED_IMM_LEN-1:0]    signed_imm_24_in,
  input  logic [REG_ADDR_W-1:0]        dest_in,
  input  logic [STATUS_REG_LEN-1:0]    stat_reg_in,
  output logic                         valid_out,
  output logic                         wb_en,
  output logic                         mem_r_en,
  output logic                         mem_w_en,
  output logic                         b,
  output logic                         s,
  output logic [EXE_CMD_W-1:0]         exe_cmd,
  output logic                         imm,
  output logic [DATA_W-1:0]            pc,
  output logic [DATA_W-1:0]            val_rn,
  output logic [DATA_W-1:0]            val_rm,
  output logic [SHIFT_OPERAND_LEN-1:0] shift_operand,
  output logic [SIGNED_IMM_LEN-1:0]    signed_imm_24,
  output logic [REG_ADDR_W-1:0]        dest,
`ifdef COND_STATS_EN
  output logic [31:0]                  exec_count,
  output logic [31:0]                  squash_count,
`endif
  output logic [STATUS_REG_LEN-1:0]    stat_reg
);
  localparam int DP_W = EXE_CMD_W + 1 + 3*DATA_W + SHIFT_OPERAND_LEN + SIGNED_IMM_LEN
                      + REG_ADDR_W + STATUS_REG_LEN;
  logic            commit;
  ctrl_t           ctrl_d, ctrl_q;
  logic [DP_W-1:0] dp_d, dp_q;
  always_comb begin
    commit = commit_of(valid_in, cond_state);
    ctrl_d = {valid_in, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in};
    dp_d   = {exe_cmd_in, imm_in, pc_in, val_rn_in, val_rm_in, shift_operand_in,
              signed_imm_24_in, dest_in, stat_reg_in};
  end
  // a failed condition turns the instruction into a bubble just like flush/hazard
  id_exe_stage_reg_pipe_reg #(.WIDTH($bits(ctrl_t))) u_ctrl (
    .clk(clk), .rst(rst), .hold(mem_stall), .clear(flush | hazard | ~commit),
    .d(ctrl_d), .q(ctrl_q)
  );
  id_exe_stage_reg_pipe_reg #(.WIDTH(DP_W)) u_dp (
    .clk(clk), .rst(rst), .hold(mem_stall), .clear(1'b0),
    .d(dp_d), .q(dp_q)
  );
  assign {valid_out, wb_en, mem_r_en, mem_w_en, b, s} = ctrl_q;
  assign {exe_cmd, imm, pc, val_rn, val_rm, shift_operand, signed_imm_24, dest, stat_reg} = dp_q;
`ifdef COND_STATS_EN
  logic        load;
  logic [31:0] exec_count_d, exec_count_q, squash_count_d, squash_count_q;
  always_comb begin
    load           = ~mem_stall & ~flush & ~hazard & valid_in;
    exec_count_d   = rst ? '0 : exec_count_q + 32'(load & cond_state);
    squash_count_d = rst ? '0 : squash_count_q + 32'(load & ~cond_state);
  end
  always_ff @(posedge clk) begin
    exec_count_q   <= exec_count_d;
    squash_count_q <= squash_count_d;
  end
  assign exec_count   = exec_count_q;
  assign squash_count = squash_count_q;
`endif
endmodule

// File: tb/tb_id_exe_stage_reg.sv
// tb_id_exe_stage_reg: table-driven check of load, squash, flush, hazard and stall priority
module tb_id_exe_stage_reg;
  logic        clk = 0, rst, mem_stall, flush, hazard, valid_in, cond_state;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
  logic [3:0]  exe_cmd_in, dest_in, stat_reg_in;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic        valid_out, wb_en, mem_r_en, mem_w_en, b, s, imm;
  logic [3:0]  exe_cmd, dest, stat_reg;
  logic [31:0] pc, val_rn, val_rm;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
`ifdef COND_STATS_EN
  logic [31:0] exec_count, squash_count;
`endif
  int total = 0, bad = 0;

  id_exe_stage_reg dut (
    .clk(clk), .rst(rst), .mem_stall(mem_stall), .flush(flush), .hazard(hazard),
    .valid_in(valid_in), .cond_state(cond_state), .wb_en_in(wb_en_in),
    .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .b_in(b_in), .s_in(s_in),
    .exe_cmd_in(exe_cmd_in), .imm_in(imm_in), .pc_in(pc_in), .val_rn_in(val_rn_in),
    .val_rm_in(val_rm_in), .shift_operand_in(shift_operand_in),
    .signed_imm_24_in(signed_imm_24_in), .dest_in(dest_in), .stat_reg_in(stat_reg_in),
    .valid_out(valid_out), .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .b(b), .s(s), .exe_cmd(exe_cmd), .imm(imm), .pc(pc), .val_rn(val_rn), .val_rm(val_rm),
    .shift_operand(shift_operand), .signed_imm_24(signed_imm_24), .dest(dest),
`ifdef COND_STATS_EN
    .exec_count(exec_count), .squash_count(squash_count),
`endif
    .stat_reg(stat_reg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st, fl, hz, vi, cs;
    logic [4:0] ctl;
    logic [3:0] cmd;
    logic [31:0] pcv, rn;
    logic [3:0] dst;
    logic       e_v;
    logic [4:0] e_ctl;
    logic [3:0] e_cmd;
    logic [31:0] e_pc, e_rn;
    logic [3:0] e_dst;
  } vec_t;
  vec_t tbl[13];

  function automatic vec_t mk(logic st, fl, hz, vi, cs, logic [4:0] ctl, logic [3:0] cmd,
                              logic [31:0] pcv, rn, logic [3:0] dst, logic e_v,
                              logic [4:0] e_ctl, logic [3:0] e_cmd, logic [31:0] e_pc, e_rn,
                              logic [3:0] e_dst);
    vec_t v;
    v.st = st; v.fl = fl; v.hz = hz; v.vi = vi; v.cs = cs; v.ctl = ctl; v.cmd = cmd;
    v.pcv = pcv; v.rn = rn; v.dst = dst; v.e_v = e_v; v.e_ctl = e_ctl; v.e_cmd = e_cmd;
    v.e_pc = e_pc; v.e_rn = e_rn; v.e_dst = e_dst;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ctl order {wb, mr, mw, b, s}
    tbl[0]  = mk(0,0,0,1,1, 5'b10000, 2, 32'h04, 5, 3,  1, 5'b10000, 2, 32'h04, 5, 3);
    tbl[1]  = mk(0,0,0,1,0, 5'b10100, 2, 32'h08, 5, 3,  0, 5'b00000, 2, 32'h08, 5, 3);
    tbl[2]  = mk(0,0,0,1,1, 5'b11111, 5, 32'h10, 6, 7,  1, 5'b11111, 5, 32'h10, 6, 7);
    tbl[3]  = mk(1,1,0,1,1, 5'b00000, 9, 32'h20, 9, 1,  1, 5'b11111, 5, 32'h10, 6, 7);
    tbl[4]  = mk(1,1,0,1,1, 5'b00000, 9, 32'h20, 9, 1,  1, 5'b11111, 5, 32'h10, 6, 7);
    tbl[5]  = mk(1,1,0,1,1, 5'b00000, 9, 32'h20, 9, 1,  1, 5'b11111, 5, 32'h10, 6, 7);
    tbl[6]  = mk(0,1,0,1,1, 5'b00000, 9, 32'h20, 9, 1,  0, 5'b00000, 9, 32'h20, 9, 1);
    tbl[7]  = mk(0,0,1,1,1, 5'b00010, 1, 32'h24, 2, 2,  0, 5'b00000, 1, 32'h24, 2, 2);
    tbl[8]  = mk(0,0,0,1,1, 5'b00010, 1, 32'h24, 2, 2,  1, 5'b00010, 1, 32'h24, 2, 2);
    tbl[9]  = mk(0,0,0,0,1, 5'b11111, 3, 32'h28, 3, 4,  0, 5'b00000, 3, 32'h28, 3, 4);
    tbl[10] = mk(0,1,1,1,1, 5'b11111, 4, 32'h2c, 4, 5,  0, 5'b00000, 4, 32'h2c, 4, 5);
    tbl[11] = mk(0,0,0,1,1, 5'b01001, 6, 32'h30, 7, 6,  1, 5'b01001, 6, 32'h30, 7, 6);
    tbl[12] = mk(1,0,1,1,1, 5'b11111, 8, 32'h34, 8, 8,  1, 5'b01001, 6, 32'h30, 7, 6);

    // reset with every input at 1, including stall
    rst = 1; mem_stall = 1; flush = 1; hazard = 1; valid_in = 1; cond_state = 1;
    wb_en_in = 1; mem_r_en_in = 1; mem_w_en_in = 1; b_in = 1; s_in = 1; imm_in = 1;
    exe_cmd_in = '1; dest_in = '1; stat_reg_in = '1; pc_in = '1; val_rn_in = '1;
    val_rm_in = '1; shift_operand_in = '1; signed_imm_24_in = '1;
    tick; tick;
    chk("rst_ctrl", {valid_out, wb_en, mem_r_en, mem_w_en, b, s}, 0);
    chk("rst_dp_a", {exe_cmd, imm, pc, val_rn, dest, stat_reg}, 0);
    chk("rst_dp_b", {val_rm, shift_operand, signed_imm_24}, 0);
`ifdef COND_STATS_EN
    chk("rst_cnt", {exec_count, squash_count}, 0);
`endif
    rst = 0;
    imm_in = 1; val_rm_in = 32'ha5a5_5a5a; shift_operand_in = 12'habc;
    signed_imm_24_in = 24'h123456; stat_reg_in = 4'b1010;

    for (int i = 0; i < 13; i++) begin
      mem_stall = tbl[i].st; flush = tbl[i].fl; hazard = tbl[i].hz;
      valid_in = tbl[i].vi; cond_state = tbl[i].cs;
      {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in} = tbl[i].ctl;
      exe_cmd_in = tbl[i].cmd; pc_in = tbl[i].pcv; val_rn_in = tbl[i].rn; dest_in = tbl[i].dst;
      tick;
      chk($sformatf("vec%0d", i),
          {valid_out, wb_en, mem_r_en, mem_w_en, b, s, exe_cmd, pc, val_rn, dest},
          {tbl[i].e_v, tbl[i].e_ctl, tbl[i].e_cmd, tbl[i].e_pc, tbl[i].e_rn, tbl[i].e_dst});
      if (i == 0)
        chk("side_fields", {imm, val_rm, shift_operand, signed_imm_24, stat_reg},
            {1'b1, 32'ha5a5_5a5a, 12'habc, 24'h123456, 4'b1010});
    end
`ifdef COND_STATS_EN
    chk("exec_count", exec_count, 4);
    chk("squash_count", squash_count, 1);
`endif

    // reset wins over an active stall
    rst = 1; mem_stall = 1;
    tick;
    chk("rst_mid_stall", {valid_out, wb_en, mem_r_en, mem_w_en, b, s, pc, dest}, 0);
`ifdef COND_STATS_EN
    chk("rst_mid_cnt", {exec_count, squash_count}, 0);
`endif
    rst = 0; mem_stall = 0; flush = 0; hazard = 0;
    valid_in = 1; cond_state = 1; {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in} = 5'b00001;
    pc_in = 32'h40;
    tick;
    chk("post_rst_load", {valid_out, wb_en, mem_r_en, mem_w_en, b, s, pc}, {6'b100001, 32'h40});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
